// File: rtl/irrigation_scheduler_pkg.sv
// Shared definitions for the irrigation scheduler: state and mode encodings,
// water-level constants, status codes and the actuator output decode.
package irrigation_scheduler_pkg;

  localparam logic [1:0] LVL_EMPTY = 2'b00;
  localparam logic [1:0] LVL_LOW   = 2'b01;
  localparam logic [1:0] LVL_HALF  = 2'b10;
  localparam logic [1:0] LVL_FULL  = 2'b11;

  localparam logic [1:0] DATA_IDLE      = 2'b00;
  localparam logic [1:0] DATA_DRIP      = 2'b01;
  localparam logic [1:0] DATA_SPRINKLER = 2'b10;
  localparam logic [1:0] DATA_SPECIFIC  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_COOL   = 2'd2,
    ST_REFILL = 2'd3
  } state_e;

  // Mode values double as the status code reported while running.
  typedef enum logic [1:0] {
    MODE_NONE      = DATA_IDLE,
    MODE_DRIP      = DATA_DRIP,
    MODE_SPRINKLER = DATA_SPRINKLER,
    MODE_SPECIFIC  = DATA_SPECIFIC
  } mode_e;

  typedef struct packed {
    logic       sprinkler;
    logic       drip;
    logic       specific;
    logic       pump;
    logic [1:0] data;
    logic       busy;
  } act_t;

  // Actuator pattern for a given state/mode; at most one valve or the pump is on.
  function automatic act_t decode_outputs(state_e st, mode_e md);
    act_t a;
    a = '0;
    unique case (st)
      ST_RUN: begin
        a.sprinkler = (md == MODE_SPRINKLER);
        a.drip      = (md == MODE_DRIP);
        a.specific  = (md == MODE_SPECIFIC);
        a.data      = md;
        a.busy      = 1'b1;
      end
      ST_COOL: begin
        a.busy = 1'b1;
      end
      ST_REFILL: begin
        a.pump = 1'b1;
        a.busy = 1'b1;
      end
      default: begin
        a = '0;
      end
    endcase
    return a;
  endfunction

endpackage

// File: rtl/irrigation_scheduler_tick_prescaler.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and pulses tick for one cycle
// while the count sits at TICK_DIV-1.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] LAST     = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(TICK_DIV - 2);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Tick is registered one count early so it lines up with count == LAST.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + DIV_W'(1);
    tick_d = (cnt_q == PRE_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/irrigation_scheduler.sv
// Turns raw irrigation requests into exclusive, time-bounded watering runs with
// minimum/maximum run length, forced cool-down and water-box refill.
module irrigation_scheduler #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned MIN_ON   = 10,
  parameter int unsigned MAX_ON   = 600,
  parameter int unsigned COOLDOWN = 60,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sprinkler_req,
  input  logic       drip_req,
  input  logic       specific_req,
  input  logic [1:0] water_box,
  output logic       sprinkler_on,
  output logic       drip_on,
  output logic       specific_on,
  output logic       pump_on,
  output logic [1:0] irrigation_data,
  output logic       busy
);

  import irrigation_scheduler_pkg::*;

  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_ON);
  localparam logic [CNT_W-1:0] COOL_C = CNT_W'(COOLDOWN);
  localparam logic [CNT_W-1:0] SAT_C  = '1;

  logic             tick;
  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] cool_cnt_q, cool_cnt_d;
  act_t             act_q;
  logic             granted_req;
  logic             run_stop;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  // Live level of the request that won the current run.
  always_comb begin
    granted_req = 1'b0;
    unique case (mode_q)
      MODE_SPRINKLER: granted_req = sprinkler_req;
      MODE_DRIP:      granted_req = drip_req;
      MODE_SPECIFIC:  granted_req = specific_req;
      default:        granted_req = 1'b0;
    endcase
  end

  // Any of MAX_ON, request drop after MIN_ON or sprinkler level drop ends a run in COOL.
  assign run_stop = (run_cnt_q >= MAX_C)
                 || (!granted_req && (run_cnt_q >= MIN_C))
                 || ((mode_q == MODE_SPRINKLER) && (water_box < LVL_HALF));

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    run_cnt_d  = run_cnt_q;
    cool_cnt_d = cool_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (water_box == LVL_EMPTY) begin
          state_d = ST_REFILL;
        end else if (sprinkler_req && (water_box >= LVL_HALF)) begin
          state_d   = ST_RUN;
          mode_d    = MODE_SPRINKLER;
          run_cnt_d = '0;
        end else if (drip_req) begin
          state_d   = ST_RUN;
          mode_d    = MODE_DRIP;
          run_cnt_d = '0;
        end else if (specific_req) begin
          state_d   = ST_RUN;
          mode_d    = MODE_SPECIFIC;
          run_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (water_box == LVL_EMPTY) begin
          state_d = ST_REFILL;
          mode_d  = MODE_NONE;
        end else if (run_stop) begin
          state_d    = ST_COOL;
          mode_d     = MODE_NONE;
          cool_cnt_d = '0;
        end else if (tick && (run_cnt_q != SAT_C)) begin
          run_cnt_d = run_cnt_q + CNT_W'(1);
        end
      end
      ST_COOL: begin
        if (cool_cnt_q >= COOL_C) begin
          state_d = (water_box == LVL_EMPTY) ? ST_REFILL : ST_IDLE;
        end else if (tick && (cool_cnt_q != SAT_C)) begin
          cool_cnt_d = cool_cnt_q + CNT_W'(1);
        end
      end
      ST_REFILL: begin
        if (water_box == LVL_FULL) begin
          state_d    = ST_COOL;
          cool_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        mode_d  = MODE_NONE;
      end
    endcase
  end

  // Outputs are decoded from the registered state, so they trail it by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_NONE;
      run_cnt_q  <= '0;
      cool_cnt_q <= '0;
      act_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      run_cnt_q  <= run_cnt_d;
      cool_cnt_q <= cool_cnt_d;
      act_q      <= decode_outputs(state_q, mode_q);
    end
  end

  assign sprinkler_on    = act_q.sprinkler;
  assign drip_on         = act_q.drip;
  assign specific_on     = act_q.specific;
  assign pump_on         = act_q.pump;
  assign irrigation_data = act_q.data;
  assign busy            = act_q.busy;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler: a phase/elapsed-tick reference model
// queues expected outputs per edge; a negedge monitor pops and compares.
module tb_irrigation_scheduler;

  localparam int TICK_DIV = 4;
  localparam int MIN_ON   = 2;
  localparam int MAX_ON   = 5;
  localparam int COOLDOWN = 3;
  localparam int CNT_W    = 8;

  localparam int P_IDLE   = 0;
  localparam int P_RUN    = 1;
  localparam int P_COOL   = 2;
  localparam int P_REFILL = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       sprinkler_req, drip_req, specific_req;
  logic [1:0] water_box;
  logic       sprinkler_on, drip_on, specific_on, pump_on;
  logic [1:0] irrigation_data;
  logic       busy;

  irrigation_scheduler #(
    .TICK_DIV(TICK_DIV),
    .MIN_ON  (MIN_ON),
    .MAX_ON  (MAX_ON),
    .COOLDOWN(COOLDOWN),
    .CNT_W   (CNT_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .sprinkler_req  (sprinkler_req),
    .drip_req       (drip_req),
    .specific_req   (specific_req),
    .water_box      (water_box),
    .sprinkler_on   (sprinkler_on),
    .drip_on        (drip_on),
    .specific_on    (specific_on),
    .pump_on        (pump_on),
    .irrigation_data(irrigation_data),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Reference model: phase, mode (as status code) and the edge at which the phase began.
  int         m_phase, m_mode, m_entry, edge_n;
  logic [6:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic logic [6:0] model_out(int ph, int md);
    logic s, d, x, p, b;
    logic [1:0] data;
    s = 1'b0; d = 1'b0; x = 1'b0; p = 1'b0; b = (ph != P_IDLE); data = 2'b00;
    if (ph == P_RUN) begin
      s    = (md == 2);
      d    = (md == 1);
      x    = (md == 3);
      data = 2'(md);
    end
    if (ph == P_REFILL) p = 1'b1;
    return {s, d, x, p, data, b};
  endfunction

  task automatic enter(int ph, int md);
    m_phase = ph;
    m_mode  = md;
    m_entry = edge_n;
  endtask

  // Ticks are seen at every edge whose index is a multiple of TICK_DIV; the count
  // visible at edge n covers tick edges strictly between entry and n.
  task automatic model_step();
    int el;
    logic req;
    el  = (edge_n - 1) / TICK_DIV - m_entry / TICK_DIV;
    req = (m_mode == 2) ? sprinkler_req : (m_mode == 1) ? drip_req : specific_req;
    case (m_phase)
      P_IDLE: begin
        if (water_box == 2'b00) enter(P_REFILL, 0);
        else if (sprinkler_req && water_box >= 2'b10) enter(P_RUN, 2);
        else if (drip_req) enter(P_RUN, 1);
        else if (specific_req) enter(P_RUN, 3);
      end
      P_RUN: begin
        if (water_box == 2'b00) enter(P_REFILL, 0);
        else if (el >= MAX_ON || (!req && el >= MIN_ON) || (m_mode == 2 && water_box < 2'b10))
          enter(P_COOL, 0);
      end
      P_COOL: begin
        if (el >= COOLDOWN) enter((water_box == 2'b00) ? P_REFILL : P_IDLE, 0);
      end
      default: begin
        if (water_box == 2'b11) enter(P_COOL, 0);
      end
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        m_phase = P_IDLE; m_mode = 0; m_entry = 0; edge_n = 0;
        exp_q.delete();
      end else begin
        edge_n++;
        exp_q.push_back(model_out(m_phase, m_mode));
        model_step();
      end
    end
  end

  task automatic check(string name, logic [6:0] act, logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got {spr,drip,spec,pump,data,busy}=%b want %b", name, $time, act, exp);
    end
  endtask

  // Monitor: one scoreboard pop per cycle plus the valve/pump exclusivity check.
  initial begin
    logic [6:0] act;
    logic [6:0] e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        act = {sprinkler_on, drip_on, specific_on, pump_on, irrigation_data, busy};
        n_cmp++;
        if ($countones({sprinkler_on, drip_on, specific_on, pump_on}) > 1) begin
          n_err++;
          $display("FAIL exclusive t=%0t got valves/pump=%b want at most one high", $time, act[6:3]);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("scoreboard", act, e);
        end
      end
    end
  end

  task automatic drive(logic s, logic d, logic x, logic [1:0] wb, int n);
    sprinkler_req = s;
    drip_req      = d;
    specific_req  = x;
    water_box     = wb;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    logic [1:0] wb;
    int r;
    reset = 1'b1;
    sprinkler_req = 1'b0; drip_req = 1'b0; specific_req = 1'b0; water_box = 2'b11;
    repeat (2) @(negedge clock);
    #1 check("reset_state", {sprinkler_on, drip_on, specific_on, pump_on, irrigation_data, busy}, 7'b0);
    @(negedge clock);
    reset = 1'b0;

    // One-cycle sprinkler pulse on a full tank: MIN_ON run, cool, idle.
    drive(1'b1, 1'b0, 1'b0, 2'b11, 1);
    drive(1'b0, 1'b0, 1'b0, 2'b11, 40);
    // Low tank with sprinkler and drip held: drip wins and runs to MAX_ON.
    drive(1'b1, 1'b1, 1'b0, 2'b01, 44);
    drive(1'b0, 1'b0, 1'b0, 2'b11, 20);
    // Drip run interrupted by an empty tank, then refill and cool.
    drive(1'b0, 1'b1, 1'b0, 2'b11, 6);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 8);
    drive(1'b0, 1'b0, 1'b0, 2'b11, 24);
    // All requests on a full tank.
    drive(1'b1, 1'b1, 1'b1, 2'b11, 44);
    drive(1'b0, 1'b0, 1'b0, 2'b11, 20);
    // Half tank sprinkler run, level drops past MIN_ON, drip follows.
    drive(1'b1, 1'b1, 1'b0, 2'b10, 14);
    drive(1'b1, 1'b1, 1'b0, 2'b01, 40);
    drive(1'b0, 1'b0, 1'b0, 2'b11, 20);

    // Asynchronous reset during a sprinkler run clears outputs immediately.
    drive(1'b1, 1'b0, 1'b0, 2'b11, 4);
    #2 reset = 1'b1;
    #1 check("reset_mid_run", {sprinkler_on, drip_on, specific_on, pump_on, irrigation_data, busy}, 7'b0);
    drive(1'b0, 1'b0, 1'b0, 2'b11, 2);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b11, 4);

    // Randomized segments weighted toward a usable tank.
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      wb = (r < 55) ? 2'b11 : (r < 72) ? 2'b10 : (r < 90) ? 2'b01 : 2'b00;
      drive(1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 40),
            1'($urandom_range(0, 99) < 35), wb, int'($urandom_range(1, 10)));
    end
    repeat (3) @(negedge clock);

    n_cmp++;
    if (n_cmp < 1000) begin
      n_err++;
      $display("FAIL coverage got %0d comparisons want at least 1000", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
